// File: rtl/op_pkg.sv
// Shared widths and types for the streaming operand adder.
// Defaults: 32-bit words, 8-deep operand and result memories.
package op_pkg;
  localparam int MEM_WIDTH_D = 32;
  localparam int MEM_DEPTH_D = 8;
  localparam int AW_D        = $clog2(MEM_DEPTH_D);

  typedef logic [AW_D-1:0]        addr_t;
  typedef logic [MEM_WIDTH_D-1:0] word_t;
endpackage

// File: rtl/result_mem.sv
// Write-only result storage, cleared by async reset.
// Ports: clk_i, rst_ni, data_i (word), addr_i (index); array mem readable by benches.
module result_mem
  import op_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_D,
  parameter int MEM_DEPTH = MEM_DEPTH_D,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MEM_WIDTH-1:0] data_i,
  input  logic [AW-1:0]        addr_i
);

  logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  // No enable: the producer keeps the address/data pair coherent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      mem[addr_i] <= data_i;
    end
  end

endmodule

// File: rtl/operation_unit.sv
// Walks 0..MEM_DEPTH-1 once, adds operand words, stores sums in result_mem.
// Ports: clk_i, rst_ni, operand1/2_i, operand1/2_addr_o, result_addr_o, result_o.
module operation_unit
  import op_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_D,
  parameter int MEM_DEPTH = MEM_DEPTH_D,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MEM_WIDTH-1:0] operand1_i,
  input  logic [MEM_WIDTH-1:0] operand2_i,
  output logic [AW-1:0]        operand1_addr_o,
  output logic [AW-1:0]        operand2_addr_o,
  output logic [AW-1:0]        result_addr_o,
  output logic [MEM_WIDTH-1:0] result_o
);

  localparam logic [AW-1:0] LAST = AW'(MEM_DEPTH - 1);

  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        res_addr_q;
  logic [MEM_WIDTH-1:0] result_q;

  always_comb begin
    rd_addr_d = rd_addr_q;
    done_d    = done_q;
    if (!done_q) begin
      if (rd_addr_q == LAST) done_d = 1'b1;
      else rd_addr_d = rd_addr_q + AW'(1);
    end
  end

  // Results keep recomputing the last address once done;
  // rewriting the same value is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      res_addr_q <= '0;
      result_q   <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      done_q     <= done_d;
      res_addr_q <= rd_addr_q;
      result_q   <= operand1_i + operand2_i;
    end
  end

  assign operand1_addr_o = rd_addr_q;
  assign operand2_addr_o = rd_addr_q;
  assign result_addr_o   = res_addr_q;
  assign result_o        = result_q;

  result_mem #(
    .MEM_WIDTH(MEM_WIDTH),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .data_i(result_q),
    .addr_i(res_addr_q)
  );

endmodule

// File: tb/tb_operation_unit.sv
// Self-checking bench for operation_unit and its result_mem.
// Table vectors, random operands, end-of-walk hold, mid-run reset.
module tb_operation_unit;
  import op_pkg::*;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op1_i, op2_i;
  logic [2:0]  a1_o, a2_o, ra_o;
  logic [31:0] res_o;

  logic [31:0] op1_m [D];
  logic [31:0] op2_m [D];
  logic [31:0] exp_m [D];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [D];

  always #5 clk = ~clk;

  assign op1_i = op1_m[a1_o];
  assign op2_i = op2_m[a2_o];

  operation_unit dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .operand1_i     (op1_i),
    .operand2_i     (op2_i),
    .operand1_addr_o(a1_o),
    .operand2_addr_o(a2_o),
    .result_addr_o  (ra_o),
    .result_o       (res_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_mem(input string nm);
    for (int i = 0; i < D; i++)
      chk($sformatf("%s mem[%0d]", nm, i), dut.u_mem.mem[i], exp_m[i]);
  endtask

  task automatic clr_exp();
    for (int i = 0; i < D; i++) exp_m[i] = 32'd0;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Releases reset mid-cycle and walks 20 edges. Reference:
  // after n edges the read address is min(n,D-1), the result
  // register holds the sum for min(n-1,D-1).
  task automatic run_walk(input string nm);
    int ri;
    for (int i = 0; i < D; i++) exp_m[i] = op1_m[i] + op2_m[i];
    rst_n = 1'b1;
    #1;
    chk({nm, " addr0"}, 32'(a1_o), 32'd0);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      ri = (n - 1 < D - 1) ? n - 1 : D - 1;
      chk($sformatf("%s a1 e%0d", nm, n), 32'(a1_o),
          32'((n < D - 1) ? n : D - 1));
      chk($sformatf("%s a2 e%0d", nm, n), 32'(a2_o),
          32'((n < D - 1) ? n : D - 1));
      chk($sformatf("%s ra e%0d", nm, n), 32'(ra_o), 32'(ri));
      chk($sformatf("%s res e%0d", nm, n), res_o, exp_m[ri]);
      if (n >= 2 && n - 2 < D)
        chk($sformatf("%s fill e%0d", nm, n), dut.u_mem.mem[n - 2],
            exp_m[n - 2]);
      if (n == 9) chk_mem({nm, " e9"});
    end
    chk_mem({nm, " e20"});
  endtask

  initial begin
    tbl[0] = '{32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFC};
    tbl[1] = '{32'd2,         32'd20,       32'd22};
    tbl[2] = '{32'd3,         32'd30,       32'd33};
    tbl[3] = '{32'hFFFF_FFFF, 32'd2,        32'd1};
    tbl[4] = '{32'd5,         32'd50,       32'd55};
    tbl[5] = '{32'd6,         32'd60,       32'd66};
    tbl[6] = '{32'd7,         32'd70,       32'd77};
    tbl[7] = '{32'd8,         32'd80,       32'd88};
    for (int i = 0; i < D; i++) begin
      op1_m[i] = 32'(i + 1);
      op2_m[i] = 32'(10 * (i + 1));
    end

    // Reset state
    repeat (2) @(negedge clk);
    clr_exp();
    chk("rst a1", 32'(a1_o), 32'd0);
    chk("rst ra", 32'(ra_o), 32'd0);
    chk("rst res", res_o, 32'd0);
    chk_mem("rst");

    // Basic walk: mem[i] = 11*(i+1)
    run_walk("basic");
    for (int i = 0; i < D; i++)
      chk($sformatf("basic 11x mem[%0d]", i), dut.u_mem.mem[i],
          32'(11 * (i + 1)));

    // Table: signed entry 0, wrap entry 3
    hold_reset();
    for (int i = 0; i < D; i++) begin
      op1_m[i] = tbl[i].op1;
      op2_m[i] = tbl[i].op2;
    end
    run_walk("tbl");
    for (int i = 0; i < D; i++)
      chk($sformatf("tbl exp[%0d]", i), dut.u_mem.mem[i], tbl[i].exp);

    // Random operands
    for (int r = 0; r < 4; r++) begin
      hold_reset();
      for (int i = 0; i < D; i++) begin
        op1_m[i] = $urandom;
        op2_m[i] = $urandom;
      end
      run_walk($sformatf("rnd%0d", r));
    end

    // Mid-run async reset at address 4
    hold_reset();
    for (int i = 0; i < D; i++) begin
      op1_m[i] = $urandom;
      op2_m[i] = $urandom;
    end
    rst_n = 1'b1;
    begin
      int k;
      k = 0;
      while (a1_o != 3'd4 && k < 20) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("mid reach4", 32'(k < 20), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    clr_exp();
    chk("mid a1", 32'(a1_o), 32'd0);
    chk("mid ra", 32'(ra_o), 32'd0);
    chk("mid res", res_o, 32'd0);
    chk_mem("mid clr");
    repeat (2) @(negedge clk);
    run_walk("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
